fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that gives NREQ requesters shared access to one async FIFO write port.
// An owner keeps the port for at most MAX_BURST accepted writes, or until it drops its request.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   wr_clk,
  input  logic                   reset_w,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic                   wr_full,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        ack,
  output logic                   write_enable,
  output logic [DWIDTH-1:0]      data_in,
  output logic [15:0]            wr_count
);

  localparam int          IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U    = NREQ;
  localparam logic [3:0]  LAST_BEAT = 4'(MAX_BURST - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last_owner;
  logic [3:0]    burst_cnt;

  logic [IW-1:0] rr_base;
  logic [IW-1:0] cand;
  logic [IW-1:0] win_idx;
  logic          win_valid;
  logic          release_now;

  // While owning, the search starts after the current owner so that the
  // winner already reflects the priority that takes effect at release.
  always_comb begin
    rr_base   = (state == OWN) ? owner : last_owner;
    cand      = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int unsigned k = 1; k <= NREQ_U; k++) begin
      cand = IW'((32'(rr_base) + k) % NREQ_U);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign ack          = grant & req & {NREQ{~wr_full}};
  assign write_enable = |ack;

  always_comb begin
    data_in = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (grant[i]) data_in = data_in | req_data[i*DWIDTH +: DWIDTH];
    end
  end

  // ack is already masked by wr_full, so a stalled burst can never reach its limit.
  assign release_now = (state == OWN) &&
                       (!req[owner] || (write_enable && (burst_cnt == LAST_BEAT)));

  always_ff @(posedge wr_clk or negedge reset_w) begin
    if (!reset_w) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IW'(NREQ - 1);
      burst_cnt  <= '0;
      wr_count   <= '0;
    end else begin
      if (write_enable) wr_count <= wr_count + 16'd1;

      case (state)
        IDLE: begin
          if (win_valid) begin
            state     <= OWN;
            grant     <= NREQ'(1) << win_idx;
            owner     <= win_idx;
            burst_cnt <= '0;
          end
        end
        OWN: begin
          if (release_now) begin
            last_owner <= owner;
            burst_cnt  <= '0;
            if (win_valid) begin
              grant <= NREQ'(1) << win_idx;
              owner <= win_idx;
            end else begin
              grant <= '0;
              state <= IDLE;
            end
          end else if (write_enable) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
